rs_lane_deframer: RTL



---
 rtl/rs_lane_deframer.sv | 113 +++++++++++
 1 files changed

// File: rtl/rs_lane_deframer.sv
// rs_lane_deframer: gathers 8 RS-decoded lanes, drops parity, replays payload as one AXI-stream block
module rs_lane_deframer #(
    parameter int LANES      = 8,
    parameter int CW_BYTES   = 255,
    parameter int DATA_BYTES = 236,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                 clk_250m,
    input  logic                 reset,
    input  logic                 s_axis_lane_tvalid,
    output logic                 s_axis_lane_tready,
    input  logic [8*LANES-1:0]   s_axis_lane_tdata,
    input  logic                 s_axis_lane_tlast,
    output logic                 m_axis_output_tvalid,
    input  logic                 m_axis_output_tready,
    output logic [7:0]           m_axis_output_tdata,
    output logic                 m_axis_output_tlast,
    output logic                 err_framing,
    output logic [BLK_CNT_W-1:0] blk_cnt
);
    localparam int IW = $clog2(CW_BYTES);
    localparam int BW = $clog2(DATA_BYTES);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] CW_LAST = IW'(CW_BYTES - 1);
    localparam logic [IW-1:0] DB_END  = IW'(DATA_BYTES);
    localparam logic [BW-1:0] DB_LAST = BW'(DATA_BYTES - 1);
    localparam logic [LW-1:0] LN_LAST = LW'(LANES - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t               state_q;
    logic [IW-1:0]        in_cnt_q;
    logic [LW-1:0]        lane_q;
    logic [BW-1:0]        byte_q;
    logic                 tready_q;
    logic                 tvalid_q;
    logic                 err_q;
    logic [BLK_CNT_W-1:0] blk_cnt_q;
    logic [7:0]           mem_q [LANES][DATA_BYTES];
    logic                 in_acc;
    logic                 out_acc;
    logic                 out_last;

    assign in_acc   = s_axis_lane_tvalid && tready_q;
    assign out_acc  = tvalid_q && m_axis_output_tready;
    assign out_last = (lane_q == LN_LAST) && (byte_q == DB_LAST);

    // payload beats land in the buffer; parity beats are simply not written
    always_ff @(posedge clk_250m) begin
        if (in_acc && in_cnt_q < DB_END) begin
            for (int k = 0; k < LANES; k++) mem_q[k][in_cnt_q[BW-1:0]] <= s_axis_lane_tdata[8*k +: 8];
        end
    end

    // frame sequencer: count input beats, then walk the buffer lane-major on the output side
    always_ff @(posedge clk_250m) begin
        if (reset) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            lane_q    <= '0;
            byte_q    <= '0;
            tready_q  <= 1'b1;
            tvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_acc) begin
                        if (in_cnt_q == CW_LAST) begin
                            in_cnt_q <= '0;
                            state_q  <= DRAIN;
                            tready_q <= 1'b0;
                            tvalid_q <= 1'b1;
                            if (!s_axis_lane_tlast) err_q <= 1'b1;
                        end else if (s_axis_lane_tlast) begin
                            in_cnt_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (byte_q == DB_LAST) begin
                            byte_q <= '0;
                            if (lane_q == LN_LAST) begin
                                lane_q    <= '0;
                                blk_cnt_q <= blk_cnt_q + 1'b1;
                                state_q   <= FILL;
                                tready_q  <= 1'b1;
                                tvalid_q  <= 1'b0;
                            end else begin
                                lane_q <= lane_q + 1'b1;
                            end
                        end else begin
                            byte_q <= byte_q + 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_axis_lane_tready   = tready_q;
    assign m_axis_output_tvalid = tvalid_q;
    assign m_axis_output_tdata  = tvalid_q ? mem_q[lane_q][byte_q] : 8'h00;
    assign m_axis_output_tlast  = tvalid_q && out_last;
    assign err_framing          = err_q;
    assign blk_cnt              = blk_cnt_q;
endmodule
